data_arbiter_2to1: RTL and testbench

DATA_ARBITER_2TO1 -- requirements
Module: data_arbiter_2to1

---
 rtl/data_arbiter_2to1_pkg.sv | 15 +
 rtl/data_arbiter_2to1_if.sv | 17 +
 rtl/data_arbiter_2to1_resp_id_fifo.sv | 65 ++++++
 rtl/data_arbiter_2to1.sv | 110 +++++++++++
 tb/tb_data_arbiter_2to1.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/data_arbiter_2to1_pkg.sv
// Shared types and defaults for the 2:1 memory-port arbiter.
package data_arbiter_2to1_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  function automatic master_id_e other_master(input master_id_e id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/data_arbiter_2to1_if.sv
// Request/response bus used on both master ports and on the memory port.
interface data_arbiter_2to1_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  gnt;
  logic                  rvalid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_arbiter_2to1_resp_id_fifo.sv
// In-order FIFO of granted master IDs; pointers wrap modulo DEPTH.
module resp_id_fifo
  import data_arbiter_2to1_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_MAX_OUTSTANDING,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  master_id_e       push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output master_id_e       head
);

  master_id_e       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= M0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= ptr_inc(wr_ptr);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_arbiter_2to1.sv
// Two masters share one memory port: round-robin selection, zero-cycle grant,
// in-order response routing and a sticky stray-response flag.
module data_arbiter_2to1
  import data_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_arbiter_2to1_if.slave   m0,
  data_arbiter_2to1_if.slave   m1,
  data_arbiter_2to1_if.master  s,
  output logic                 protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  master_id_e            prio;
  master_id_e            sel;
  master_id_e            head;
  logic                  full;
  logic                  empty;
  logic [CNT_W-1:0]      count;
  logic                  grant;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            sel_be;
  logic                  sel_we;

  // Master selection and request field mux.
  always_comb begin
    sel       = M0;
    sel_addr  = m0.addr;
    sel_we    = m0.we;
    sel_be    = m0.be;
    sel_wdata = m0.wdata;
    if (m0.req && m1.req) begin
      sel = prio;
    end else if (m1.req) begin
      sel = M1;
    end else begin
      sel = M0;
    end
    if (sel == M1) begin
      sel_addr  = m1.addr;
      sel_we    = m1.we;
      sel_be    = m1.be;
      sel_wdata = m1.wdata;
    end else begin
      sel_addr  = m0.addr;
      sel_we    = m0.we;
      sel_be    = m0.be;
      sel_wdata = m0.wdata;
    end
  end

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
  assign s.req   = (m0.req | m1.req) & ~full;
  assign s.addr  = sel_addr;
  assign s.we    = sel_we;
  assign s.be    = sel_be;
  assign s.wdata = sel_wdata;

  assign grant     = s.req & s.gnt & rst_ni;
  assign pop       = s.rvalid & ~empty & rst_ni;
  assign m0.gnt    = grant & (sel == M0);
  assign m1.gnt    = grant & (sel == M1);
  assign m0.rvalid = pop & (head == M0);
  assign m1.rvalid = pop & (head == M1);
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;

  resp_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_resp_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (grant),
    .push_id (sel),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

  // Round-robin priority; only moves on an actual grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio <= M0;
    end else if (grant) begin
      prio <= other_master(sel);
    end else begin
      prio <= prio;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      protocol_err_o <= 1'b0;
    end else if (s.rvalid && (count == CNT_W'(0))) begin
      protocol_err_o <= 1'b1;
    end else begin
      protocol_err_o <= protocol_err_o;
    end
  end

endmodule

// File: tb/tb_data_arbiter_2to1.sv
// Directed bench for data_arbiter_2to1 with hand-computed expectations.
module tb_data_arbiter_2to1;

  logic clk;
  logic rst_n;
  logic err;
  int   n_vec;
  int   n_err;

  data_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  data_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  data_arbiter_2to1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

  data_arbiter_2to1 #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .s              (s_bus),
    .protocol_err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grants(input string tag, input logic g0, input logic g1);
    #1;
    check_vec({tag, " m0_gnt"}, 64'(m0_bus.gnt), 64'(g0));
    check_vec({tag, " m1_gnt"}, 64'(m1_bus.gnt), 64'(g1));
  endtask

  task automatic check_rvalids(input string tag, input logic r0, input logic r1);
    check_vec({tag, " m0_rvalid"}, 64'(m0_bus.rvalid), 64'(r0));
    check_vec({tag, " m1_rvalid"}, 64'(m1_bus.rvalid), 64'(r1));
  endtask

  initial begin
    logic [1:0] exp_g [4];
    logic [1:0] exp_r [4];
    logic [31:0] exp_a [4];
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    m0_bus.req = 1'b0; m0_bus.addr = 32'h0; m0_bus.we = 1'b0; m0_bus.be = 4'hF; m0_bus.wdata = 32'h0;
    m1_bus.req = 1'b0; m1_bus.addr = 32'h0; m1_bus.we = 1'b0; m1_bus.be = 4'hF; m1_bus.wdata = 32'h0;
    s_bus.gnt = 1'b0; s_bus.rvalid = 1'b0; s_bus.rdata = 32'h0;

    // Reset: outputs quiet even with requests and memory handshakes active.
    step();
    m0_bus.req = 1'b1; s_bus.gnt = 1'b1; s_bus.rvalid = 1'b1;
    check_grants("reset", 1'b0, 1'b0);
    check_rvalids("reset", 1'b0, 1'b0);
    check_vec("reset err", 64'(err), 64'd0);
    m0_bus.req = 1'b0; s_bus.gnt = 1'b0; s_bus.rvalid = 1'b0;
    step();
    rst_n = 1'b1;

    // Single master read at 0x10, response one cycle later.
    step();
    m0_bus.req = 1'b1; m0_bus.addr = 32'h10; s_bus.gnt = 1'b1;
    check_grants("single", 1'b1, 1'b0);
    check_vec("single s_req", 64'(s_bus.req), 64'd1);
    check_vec("single s_addr", 64'(s_bus.addr), 64'h10);
    step();
    m0_bus.req = 1'b0; s_bus.rvalid = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
    #1;
    check_rvalids("single", 1'b1, 1'b0);
    check_vec("single rdata", 64'(m0_bus.rdata), 64'hCAFE_F00D);
    step();
    s_bus.rvalid = 1'b0;

    // Contention from reset: grants M0,M1,M0,M1; responses trail by one cycle.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    m0_bus.req = 1'b1; m0_bus.addr = 32'h100;
    m1_bus.req = 1'b1; m1_bus.addr = 32'h200;
    s_bus.gnt = 1'b1;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    exp_r[0] = 2'b00; exp_r[1] = 2'b01; exp_r[2] = 2'b10; exp_r[3] = 2'b01;
    exp_a[0] = 32'h100; exp_a[1] = 32'h200; exp_a[2] = 32'h100; exp_a[3] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      s_bus.rvalid = (i > 0);
      check_grants($sformatf("rr%0d", i), exp_g[i][0], exp_g[i][1]);
      check_rvalids($sformatf("rr%0d", i), exp_r[i][0], exp_r[i][1]);
      check_vec($sformatf("rr%0d s_addr", i), 64'(s_bus.addr), 64'(exp_a[i]));
      step();
    end
    m0_bus.req = 1'b0; m1_bus.req = 1'b0;
    #1;
    check_rvalids("rr drain", 1'b0, 1'b1);
    step();
    s_bus.rvalid = 1'b0;

    // Backpressure: two grants, then the port goes quiet.
    m0_bus.req = 1'b1; m0_bus.addr = 32'h300;
    check_grants("bp0", 1'b1, 1'b0);
    step();
    check_grants("bp1", 1'b1, 1'b0);
    step();
    check_grants("bp full", 1'b0, 1'b0);
    check_vec("bp full s_req", 64'(s_bus.req), 64'd0);
    step();
    // Recovery: response while full blocks grant this cycle, not the next.
    s_bus.rvalid = 1'b1;
    check_grants("bp pop", 1'b0, 1'b0);
    check_rvalids("bp pop", 1'b1, 1'b0);
    step();
    s_bus.rvalid = 1'b0;
    check_grants("bp resume", 1'b1, 1'b0);
    step();
    m0_bus.req = 1'b0; s_bus.rvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_rvalids($sformatf("bp drain%0d", i), 1'b1, 1'b0);
      step();
    end
    s_bus.rvalid = 1'b0;

    // Stall: prio points at M1, memory withholds grant for 5 cycles.
    m0_bus.req = 1'b1; m0_bus.addr = 32'h400;
    m1_bus.req = 1'b1; m1_bus.addr = 32'h500;
    s_bus.gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_grants($sformatf("stall%0d", i), 1'b0, 1'b0);
      check_vec($sformatf("stall%0d s_addr", i), 64'(s_bus.addr), 64'h500);
      step();
    end
    s_bus.gnt = 1'b1;
    check_grants("stall release", 1'b0, 1'b1);
    step();
    check_grants("stall next", 1'b1, 1'b0);
    step();
    m0_bus.req = 1'b0; m1_bus.req = 1'b0; s_bus.rvalid = 1'b1;
    #1;
    check_rvalids("stall drain0", 1'b0, 1'b1);
    step();
    #1;
    check_rvalids("stall drain1", 1'b1, 1'b0);
    step();

    // Stray response with nothing outstanding.
    #1;
    check_rvalids("stray", 1'b0, 1'b0);
    check_vec("stray err same cycle", 64'(err), 64'd0);
    step();
    s_bus.rvalid = 1'b0;
    check_vec("stray err set", 64'(err), 64'd1);
    step();
    step();
    check_vec("stray err held", 64'(err), 64'd1);

    // Reset with two outstanding, applied between clock edges.
    m0_bus.req = 1'b1; m0_bus.addr = 32'h600;
    step();
    step();
    check_grants("pre-rst full", 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async rst err", 64'(err), 64'd0);
    check_vec("async rst s_req", 64'(s_bus.req), 64'd1);
    check_grants("async rst", 1'b0, 1'b0);
    m0_bus.req = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    s_bus.rvalid = 1'b1;
    #1;
    check_rvalids("post-rst stray", 1'b0, 1'b0);
    step();
    s_bus.rvalid = 1'b0;
    check_vec("post-rst err", 64'(err), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
